// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction-memory loader/fetch sequencer with redirect and fault handling
module imem_fetch_ctrl #(
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              boot_en_i,
  input  logic              ld_valid_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [31:0]       ld_data_i,
  output logic              ld_ready_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic              imem_we_o,
  output logic [31:0]       imem_wdata_o,
  input  logic [31:0]       imem_rdata_i,
  input  logic              redirect_valid_i,
  input  logic [31:0]       redirect_pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_instr_o,
  output logic [31:0]       out_pc_o,
  output logic              fault_o
);

  localparam int PC_HI = ADDR_W + 2;

  typedef enum logic [1:0] {S_LOAD, S_FETCH, S_FAULT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;

  logic pc_bad;
  logic redir_bad;
  logic take;
  logic consumed;

  assign pc_bad    = (pc_q[1:0] != 2'b00) || (pc_q[31:PC_HI] != '0);
  assign redir_bad = (redirect_pc_i[1:0] != 2'b00);
  assign take      = !out_valid_q || out_ready_i;
  assign consumed  = out_valid_q && out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD: begin
        if (!boot_en_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (redirect_valid_i) begin
          if (redir_bad) state_d = S_FAULT;
        end else if (pc_bad) begin
          state_d = S_FAULT;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    ld_ready_o   = 1'b0;
    imem_we_o    = 1'b0;
    imem_addr_o  = pc_q[PC_HI-1:2];
    imem_wdata_o = '0;
    fault_o      = 1'b0;
    case (state_q)
      S_LOAD: begin
        ld_ready_o   = 1'b1;
        imem_we_o    = ld_valid_i;
        imem_addr_o  = ld_addr_i;
        imem_wdata_o = ld_data_i;
      end
      S_FAULT: fault_o = 1'b1;
      default: ;
    endcase
  end

  // Redirect outranks the range check so a branch can rescue a pc that just ran off the end.
  always_comb begin
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    case (state_q)
      S_LOAD: begin
        if (!boot_en_i) pc_d = RESET_PC;
      end
      S_FETCH: begin
        if (redirect_valid_i) begin
          out_valid_d = 1'b0;
          pc_d        = redirect_pc_i;
        end else if (pc_bad) begin
          if (consumed) out_valid_d = 1'b0;
        end else if (take) begin
          out_valid_d = 1'b1;
          out_instr_d = imem_rdata_i;
          out_pc_d    = pc_q;
          pc_d        = pc_q + 32'd4;
        end
      end
      S_FAULT: begin
        if (consumed) out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else begin
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_instr_o = out_instr_q;
  assign out_pc_o    = out_pc_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - scoreboard bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int LIMIT = DEPTH * 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          boot_en;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          ld_ready;
  logic [AW-1:0] imem_addr;
  logic          imem_we;
  logic [31:0]   imem_wdata;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic          fault;

  imem_fetch_ctrl #(.ADDR_W(AW), .RESET_PC(32'h0)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .boot_en_i       (boot_en),
    .ld_valid_i      (ld_valid),
    .ld_addr_i       (ld_addr),
    .ld_data_i       (ld_data),
    .ld_ready_o      (ld_ready),
    .imem_addr_o     (imem_addr),
    .imem_we_o       (imem_we),
    .imem_wdata_o    (imem_wdata),
    .imem_rdata_i    (imem_rdata),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_instr_o     (out_instr),
    .out_pc_o        (out_pc),
    .fault_o         (fault)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  always @(posedge clk) if (imem_we) mem[imem_addr] <= imem_wdata;
  assign imem_rdata = mem[imem_addr];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } xfer_t;

  xfer_t       exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          exp_fault;
  bit          redir_pending;
  logic [31:0] redir_target;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit tgt_ok(input logic [31:0] t);
    return (t[1:0] == 2'b00) && (t < LIMIT);
  endfunction

  // Expected delivery stream from a start pc: sequential words up to the last one, then fault.
  task automatic push_segment(input logic [31:0] start);
    xfer_t x;
    exp_q.delete();
    if (!tgt_ok(start)) begin
      exp_fault = 1'b1;
    end else begin
      for (int p = int'(start); p < LIMIT; p += 4) begin
        x.pc    = 32'(p);
        x.instr = ref_mem[p >> 2];
        exp_q.push_back(x);
      end
    end
  endtask

  // Monitor: pops on every handshake and checks bubble, latency, hold and throughput rules.
  logic        p_valid, p_ready, p_redir, p_redir2, p_more;
  logic [31:0] p_pc, p_instr, p_tgt, p_tgt2;

  always @(negedge clk) begin
    xfer_t x;
    if (rst) begin
      p_valid = 0; p_ready = 0; p_redir = 0; p_redir2 = 0; p_more = 0;
      p_pc = 0; p_instr = 0; p_tgt = 0; p_tgt2 = 0;
    end else begin
      if (p_redir) begin
        check("bubble", 32'(out_valid), 32'd0);
      end else if (p_redir2 && tgt_ok(p_tgt2)) begin
        check("redirect_latency", 32'(out_valid), 32'd1);
      end else if (p_valid && !p_ready) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_pc", out_pc, p_pc);
        check("hold_instr", out_instr, p_instr);
      end else if (p_valid && p_ready && p_more) begin
        check("throughput", 32'(out_valid), 32'd1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_xfer: got pc %h instr %h expected no transfer", out_pc, out_instr);
        end else begin
          x = exp_q.pop_front();
          check("xfer_pc", out_pc, x.pc);
          check("xfer_instr", out_instr, x.instr);
        end
      end
      p_valid  = out_valid;
      p_ready  = out_ready;
      p_pc     = out_pc;
      p_instr  = out_instr;
      p_redir2 = p_redir;
      p_tgt2   = p_tgt;
      p_redir  = redirect_valid;
      p_tgt    = redirect_pc;
      p_more   = (exp_q.size() > 0);
    end
  end

  task automatic cycle(input int ready_pct, input int redir_pct);
    int          k;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    if (redir_pending) begin
      push_segment(redir_target);
      redir_pending = 1'b0;
    end
    out_ready      = ($urandom_range(99) < ready_pct);
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    if (!exp_fault && exp_q.size() >= 2 && $urandom_range(99) < redir_pct) begin
      k = $urandom_range(9);
      if (k == 0)      tgt = ($urandom_range(DEPTH - 1) * 4) | $urandom_range(3, 1);
      else if (k == 1) tgt = 32'(LIMIT) << $urandom_range(24, 0);
      else             tgt = $urandom_range(DEPTH - 1) * 4;
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      redir_pending  = 1'b1;
      redir_target   = tgt;
    end
  endtask

  task automatic boot(input bit spec_prog);
    logic [31:0] d;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    exp_q.delete();
    exp_fault      = 1'b0;
    redir_pending  = 1'b0;
    redirect_valid = 1'b0;
    boot_en        = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      d = $urandom;
      if (spec_prog && a == 0) d = 32'h0000_0013;
      if (spec_prog && a == 1) d = 32'h0010_0093;
      if (spec_prog && a == 2) d = 32'h0020_0113;
      ld_valid   = 1'b1;
      ld_addr    = AW'(a);
      ld_data    = d;
      ref_mem[a] = d;
      out_ready  = $urandom_range(1);
      #1;
      if (a == 5) begin
        check("ld_we", 32'(imem_we), 32'd1);
        check("ld_addr", 32'(imem_addr), 32'd5);
        check("ld_wdata", imem_wdata, d);
      end
      @(posedge clk);
      #1;
    end
    ld_valid = 1'b0;
    push_segment(32'h0);
    boot_en = 1'b0;
    @(posedge clk);
    #1;
    check("fetch_ld_ready", 32'(ld_ready), 32'd0);
    check("fetch_we", 32'(imem_we), 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_q.size() > 0 || redir_pending); i++) cycle(100, 0);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    cycle(100, 0);
    cycle(100, 0);
    check("end_fault", 32'(fault), 32'd1);
    check("end_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; boot_en = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    exp_fault = 1'b0; redir_pending = 1'b0; redir_target = '0;
    for (int a = 0; a < DEPTH; a++) begin
      mem[a]     = '0;
      ref_mem[a] = '0;
    end

    // Spec program, steady stream, 3-cycle stall, redirect to 0x10 on a live handshake, run to end.
    boot(1'b1);
    for (int i = 0; i < 4; i++) cycle(100, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0);
    @(posedge clk);
    #1;
    check("pre_redirect_valid", 32'(out_valid), 32'd1);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    redir_pending  = 1'b1;
    redir_target   = 32'h10;
    drain();

    // Misaligned redirect faults on the next cycle and stops fetching.
    boot(1'b0);
    cycle(100, 0);
    cycle(100, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h6;
    redir_pending  = 1'b1;
    redir_target   = 32'h6;
    cycle(100, 0);
    check("misalign_fault", 32'(fault), 32'd1);
    check("misalign_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(100, 0);
      check("fault_no_fetch", 32'(out_valid), 32'd0);
    end

    // Reset during FETCH with an instruction held.
    boot(1'b0);
    for (int i = 0; i < 5; i++) cycle(0, 0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);

    for (int r = 0; r < 8; r++) begin
      boot(1'b0);
      for (int i = 0; i < 150; i++) cycle(70, 8);
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
